power_sequencer: RTL
====================

# power_sequencer

Central power-up/power-down controller for the PMIC. It enables the supply stages in order and gates each step on that stage's rail-good signal plus a settle delay. On a ramp timeout or a rail dropout it performs an orderly reverse-order shutdown, then retries a bounded number of times before latching a fault. It sits between the per-stage rail-good outputs of the rail monitors and the regulator enable pins, and runs on the slow (~1 kHz) clock.

## Interface
Parameters:
- STAGES, 3: number of sequenced stages (2..8).
- ENABLE_TIMEOUT, 1000: maximum cycles in RAMP waiting for stage good.
- SETTLE_DELAY, 100: cycles a stage must stay good before the next stage is enabled.
- SHUTDOWN_DELAY, 50: cycles between disabling successive stages.
- RETRY_DELAY, 2000: cycles spent off before a retry.
- MAX_RETRIES, 3: automatic retries before latching FAULT (0..15).

Ports:
- i_clk, in, 1: slow clock; sole clock.
- i_reset, in, 1: synchronous, active-high reset.
- i_enable, in, 1: level; high requests power-up, low requests orderly power-down.
- i_stageGood, in, STAGES: per-stage rail-good, bit 0 = first stage.
- i_clearFault, in, 1: one-cycle pulse; leaves FAULT.
- o_stageEnable, out, STAGES: registered regulator enables.
- o_allUp, out, 1: high while in RUN.
- o_state, out, 3: current state code.
- o_fault, out, 1: high in FAULT.
- o_faultStage, out, 3: stage index of the most recent fault.
- o_faultCode, out, 2: 0 none, 1 ramp timeout, 2 dropout.
- o_retryCount, out, 4: retries used in the current power-up attempt.

## Operation
- State codes: IDLE=0, RAMP=1, SETTLE=2, RUN=3, SHUTDOWN=4, RETRY_WAIT=5, FAULT=6.
- Internal registers: stage index k; a single shared timer; a pending-fault flag.
- IDLE: when i_enable=1, set k=0, set o_stageEnable[0], go to RAMP.
- RAMP(k): i_stageGood[k]=1 goes to SETTLE. If the timer reaches ENABLE_TIMEOUT-1 with good still low, raise fault code 1 with stage k and go to SHUTDOWN.
- SETTLE(k): after SETTLE_DELAY cycles:
  - if k<STAGES-1, increment k, set o_stageEnable[k], go to RAMP;
  - otherwise go to RUN.
- Dropout, checked in RAMP, SETTLE and RUN: any enabled stage already qualified (index <k, or <=k in SETTLE/RUN) with good=0 raises code 2, records the lowest such index, and goes to SHUTDOWN.
- i_enable=0 in RAMP, SETTLE or RUN goes to SHUTDOWN with no fault.
- SHUTDOWN:
  - Clear the highest set enable bit on entry, then again every SHUTDOWN_DELAY cycles.
  - Once all enables are 0 and a further SHUTDOWN_DELAY has elapsed, choose the exit:
    - pending fault and retries < MAX_RETRIES: increment o_retryCount, go to RETRY_WAIT;
    - pending fault and retries exhausted: go to FAULT;
    - no fault: go to IDLE and clear o_retryCount.
- RETRY_WAIT: after RETRY_DELAY cycles, if i_enable=1 then k=0, set enable[0], go to RAMP; otherwise go to IDLE and clear retries.
- FAULT: all enables 0 and o_fault=1. i_clearFault goes to IDLE and clears o_retryCount, o_faultCode and o_faultStage.
- Reporting and exit rules:
  - o_faultCode and o_faultStage persist through retries and are overwritten by each new fault.
  - A successful reach of RUN clears o_retryCount but keeps the fault code for diagnostics.
- Simultaneous events, by priority:
  - dropout beats timeout;
  - a fault beats i_enable falling (the fault is recorded);
  - good rising on the timeout cycle counts as success.
- Ignored inputs:
  - i_enable changes during SHUTDOWN do not abort the shutdown;
  - i_stageGood is ignored in SHUTDOWN, RETRY_WAIT and FAULT;
  - i_clearFault outside FAULT is ignored.

## Timing
- Reset values: o_stageEnable=0, o_allUp=0, o_state=IDLE, o_fault=0, o_faultStage=0, o_faultCode=0, o_retryCount=0; timer=0, k=0, pending-fault flag=0.
- Reset wins over every other input, mid-sequence included: all enables drop on the next edge with no orderly shutdown.
- All outputs are registered and change on the edge that changes state. Inputs sampled in cycle n take effect at edge n+1.
- The timer resets on every state entry and on every stage-disable step in SHUTDOWN. It is $clog2 of the largest delay parameter plus 1 bits wide.
- Cycles per state:
  - RAMP: at most ENABLE_TIMEOUT cycles.
  - SETTLE: exactly SETTLE_DELAY cycles.
  - RETRY_WAIT: exactly RETRY_DELAY cycles.
  - SHUTDOWN: (number enabled at entry + 1) × SHUTDOWN_DELAY cycles.
- Best-case power-up latency, IDLE to RUN with goods already high: STAGES × (1 + SETTLE_DELAY) cycles.

## Structure
- Package pmic_pkg holds:
  - the state enumeration (3-bit codes above);
  - the fault codes FAULT_NONE, FAULT_TIMEOUT and FAULT_DROPOUT;
  - a function returning the highest-set-bit index.
- Sub-module seq_timer: a load/count/terminal-count pulse with a DELAY input port. One instance serves all states.

## Test plan
Bench parameters: STAGES=3, ENABLE_TIMEOUT=8, SETTLE_DELAY=4, SHUTDOWN_DELAY=3, RETRY_DELAY=5, MAX_RETRIES=2.
- Normal power-up: goods follow enables after 2 cycles → enables 001, 011, 111; o_allUp after 18 cycles; o_faultCode=0.
- Orderly power-down: in RUN, drop i_enable → enables 011, 001, 000 at 3-cycle spacing; IDLE 12 cycles after entering SHUTDOWN; no fault.
- Ramp timeout with recovery: stage 1 good stuck low → fault code 1, stage 1, two retries. Good released during the 2nd retry → RUN with o_retryCount=0.
- Permanent timeout: stage 1 good stuck low → after retry 2 fails, state FAULT, enables 000, o_fault=1. i_clearFault → IDLE with all fault fields 0.
- Dropout priority: in RAMP(2), drop goods 0 and 1 on the timeout cycle → code 2, stage 0.
- Reset mid-sequence: assert i_reset in SETTLE(1) → next edge enables=000, state IDLE, all outputs at reset values.

Source files
------------

// File: rtl/pmic_pkg.sv
// pmic_pkg: shared types and helpers for the PMIC power sequencer.
//   state_e     - sequencer state codes (3 bits, exposed on o_state)
//   FAULT_*     - fault cause codes (exposed on o_faultCode)
//   highest_set - index of the most significant set bit of an 8-bit vector
//   lowest_set  - index of the least significant set bit of an 8-bit vector
package pmic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RAMP       = 3'd1,
    ST_SETTLE     = 3'd2,
    ST_RUN        = 3'd3,
    ST_SHUTDOWN   = 3'd4,
    ST_RETRY_WAIT = 3'd5,
    ST_FAULT      = 3'd6
  } state_e;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_TIMEOUT = 2'd1;
  localparam logic [1:0] FAULT_DROPOUT = 2'd2;

  function automatic logic [2:0] highest_set(input logic [7:0] vec);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [2:0] lowest_set(input logic [7:0] vec);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// seq_timer: shared down-counting delay timer for the power sequencer.
//   clk   - sequencer clock
//   reset - synchronous active-high reset (count to zero)
//   load  - restart the delay; the count is loaded with delay-1
//   delay - length of the delay in cycles (one bit wider than the counter so
//           that delays up to twice the largest parameter can be expressed)
//   tc    - terminal count: high during the last cycle of the delay
module seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W:0]   delay,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = W'(delay - (W+1)'(1));
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/power_sequencer.sv
// power_sequencer: ordered power-up / reverse-order power-down of the PMIC
// supply stages, with ramp timeout, dropout detection and bounded retries.
//   i_clk, i_reset      - slow clock, synchronous active-high reset
//   i_enable            - level: 1 = power up, 0 = orderly power down
//   i_stageGood         - per-stage rail-good (bit 0 = first stage)
//   i_clearFault        - pulse, leaves FAULT
//   o_stageEnable       - registered regulator enables
//   o_allUp / o_fault   - in RUN / in FAULT
//   o_state             - current state code
//   o_faultStage/Code   - most recent fault stage and cause
//   o_retryCount        - retries used in the current power-up attempt
//
// state       | meaning
// IDLE        | all off, waiting for i_enable
// RAMP        | stage k enabled, waiting for its rail-good
// SETTLE      | stage k good, waiting SETTLE_DELAY before the next stage
// RUN         | all stages up
// SHUTDOWN    | disabling stages highest-first, SHUTDOWN_DELAY apart
// RETRY_WAIT  | all off after a fault, waiting RETRY_DELAY before retrying
// FAULT       | retries exhausted, waiting for i_clearFault
module power_sequencer
  import pmic_pkg::*;
#(
  parameter int STAGES         = 3,
  parameter int ENABLE_TIMEOUT = 1000,
  parameter int SETTLE_DELAY   = 100,
  parameter int SHUTDOWN_DELAY = 50,
  parameter int RETRY_DELAY    = 2000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [STAGES-1:0] i_stageGood,
  input  logic              i_clearFault,
  output logic [STAGES-1:0] o_stageEnable,
  output logic              o_allUp,
  output logic [2:0]        o_state,
  output logic              o_fault,
  output logic [2:0]        o_faultStage,
  output logic [1:0]        o_faultCode,
  output logic [3:0]        o_retryCount
);

  localparam int MAX_A   = (ENABLE_TIMEOUT > SETTLE_DELAY) ? ENABLE_TIMEOUT : SETTLE_DELAY;
  localparam int MAX_B   = (SHUTDOWN_DELAY > RETRY_DELAY) ? SHUTDOWN_DELAY : RETRY_DELAY;
  localparam int MAX_DLY = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW      = $clog2(MAX_DLY) + 1;
  localparam int DW      = TW + 1;
  localparam logic [2:0]        LAST_STAGE  = 3'(STAGES - 1);
  localparam logic [3:0]        RETRY_LIMIT = 4'(MAX_RETRIES);
  localparam logic [STAGES-1:0] ONE_HOT0    = STAGES'(1);

  state_e            state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic [STAGES-1:0] en_q, en_d;
  logic [1:0]        code_q, code_d;
  logic [2:0]        fstage_q, fstage_d;
  logic [3:0]        retry_q, retry_d;
  logic              pend_q, pend_d;
  logic              all_up_q, all_up_d;
  logic              fault_q, fault_d;

  logic              tmr_load, tmr_tc, step;
  logic [DW-1:0]     tmr_dly;
  logic [STAGES-1:0] qual, drop, en_hi_clr;
  logic              good_k;
  logic              sd_req, sd_flt;
  logic [1:0]        sd_code;
  logic [2:0]        sd_stage;

  seq_timer #(.W(TW)) u_timer (
    .clk   (i_clk),
    .reset (i_reset),
    .load  (tmr_load),
    .delay (tmr_dly),
    .tc    (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    en_d     = en_q;
    code_d   = code_q;
    fstage_d = fstage_q;
    retry_d  = retry_q;
    pend_d   = pend_q;
    step     = 1'b0;
    sd_req   = 1'b0;
    sd_flt   = 1'b0;
    sd_code  = FAULT_NONE;
    sd_stage = '0;

    // Stages already qualified: below k while ramping, up to k once k is good.
    qual = '0;
    for (int i = 0; i < STAGES; i++) begin
      qual[i] = (3'(i) < k_q) || ((3'(i) == k_q) && (state_q != ST_RAMP));
    end
    drop      = qual & en_q & ~i_stageGood;
    good_k    = |(i_stageGood & (ONE_HOT0 << k_q));
    en_hi_clr = en_q & ~(ONE_HOT0 << highest_set(8'(en_q)));

    case (state_q)
      ST_IDLE: begin
        if (i_enable) begin
          k_d     = '0;
          en_d    = ONE_HOT0;
          state_d = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (|drop) begin
          sd_req = 1'b1; sd_flt = 1'b1;
          sd_code = FAULT_DROPOUT; sd_stage = lowest_set(8'(drop));
        end else if (!good_k && tmr_tc) begin
          sd_req = 1'b1; sd_flt = 1'b1;
          sd_code = FAULT_TIMEOUT; sd_stage = k_q;
        end else if (!i_enable) begin
          sd_req = 1'b1;
        end else if (good_k) begin
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (|drop) begin
          sd_req = 1'b1; sd_flt = 1'b1;
          sd_code = FAULT_DROPOUT; sd_stage = lowest_set(8'(drop));
        end else if (!i_enable) begin
          sd_req = 1'b1;
        end else if (tmr_tc) begin
          if (k_q < LAST_STAGE) begin
            k_d     = k_q + 3'd1;
            en_d    = en_q | (ONE_HOT0 << k_d);
            state_d = ST_RAMP;
          end else begin
            retry_d = '0;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (|drop) begin
          sd_req = 1'b1; sd_flt = 1'b1;
          sd_code = FAULT_DROPOUT; sd_stage = lowest_set(8'(drop));
        end else if (!i_enable) begin
          sd_req = 1'b1;
        end
      end
      ST_SHUTDOWN: begin
        if (tmr_tc) begin
          if (en_q != '0) begin
            en_d = en_hi_clr;
            step = 1'b1;
          end else begin
            pend_d = 1'b0;
            if (!pend_q) begin
              retry_d = '0;
              state_d = ST_IDLE;
            end else if (retry_q < RETRY_LIMIT) begin
              retry_d = retry_q + 4'd1;
              state_d = ST_RETRY_WAIT;
            end else begin
              state_d = ST_FAULT;
            end
          end
        end
      end
      ST_RETRY_WAIT: begin
        if (tmr_tc) begin
          if (i_enable) begin
            k_d     = '0;
            en_d    = ONE_HOT0;
            state_d = ST_RAMP;
          end else begin
            retry_d = '0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_FAULT: begin
        en_d = '0;
        if (i_clearFault) begin
          retry_d  = '0;
          code_d   = FAULT_NONE;
          fstage_d = '0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (sd_req) begin
      state_d = ST_SHUTDOWN;
      en_d    = en_hi_clr;
      pend_d  = sd_flt;
      if (sd_flt) begin
        code_d   = sd_code;
        fstage_d = sd_stage;
      end
    end

    // Once the last enable is gone the wait covers both the final step gap
    // and the post-off delay, so it is loaded as twice the step delay.
    tmr_load = (state_d != state_q) || step;
    case (state_d)
      ST_RAMP:       tmr_dly = DW'(ENABLE_TIMEOUT);
      ST_SETTLE:     tmr_dly = DW'(SETTLE_DELAY);
      ST_SHUTDOWN:   tmr_dly = (en_d == '0) ? DW'(2 * SHUTDOWN_DELAY) : DW'(SHUTDOWN_DELAY);
      ST_RETRY_WAIT: tmr_dly = DW'(RETRY_DELAY);
      default:       tmr_dly = DW'(1);
    endcase

    all_up_d = (state_d == ST_RUN);
    fault_d  = (state_d == ST_FAULT);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      en_q     <= '0;
      code_q   <= FAULT_NONE;
      fstage_q <= '0;
      retry_q  <= '0;
      pend_q   <= 1'b0;
      all_up_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      en_q     <= en_d;
      code_q   <= code_d;
      fstage_q <= fstage_d;
      retry_q  <= retry_d;
      pend_q   <= pend_d;
      all_up_q <= all_up_d;
      fault_q  <= fault_d;
    end
  end

  assign o_stageEnable = en_q;
  assign o_allUp       = all_up_q;
  assign o_state       = state_q;
  assign o_fault       = fault_q;
  assign o_faultStage  = fstage_q;
  assign o_faultCode   = code_q;
  assign o_retryCount  = retry_q;

endmodule
